trail_stack: RTL
================

# trail_stack

Parametrised assignment trail for the DPLL core. It replaces the fixed-depth imply/trace stacks with one LIFO of (type, val, var) entries and tracks the current decision level. It also executes a hardware backtrack: it unwinds forced entries down to the most recent decision and flips that decision in place. It sits between control, the conflict detector (forced pushes) and the decider (decision pushes).

## Interface
- DEPTH, 64, entry capacity (≥2)
- VAR_BITS, `MAX_VARS_BITS, variable index width
- CNT_BITS, $clog2(DEPTH+1), width of count/level
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-high; clears all state
- push  in  1  push one entry (ignored while busy)
- push_type  in  1  0 = decide, 1 = forced
- push_val  in  1  assigned value
- push_var  in  VAR_BITS  variable index
- pop  in  1  pop top entry (ignored while busy)
- backtrack  in  1  start unwind (ignored while busy)
- top_type/top_val/top_var  out  1/1/VAR_BITS  current top entry; all 0 when empty
- count  out  CNT_BITS  entries held
- level  out  CNT_BITS  decision entries held
- empty, full  out  1  count==0 / count==DEPTH
- busy  out  1  high in UNWIND
- unassign_valid  out  1  entry removed this cycle; var must be cleared
- unassign_var  out  VAR_BITS  removed variable
- flip_valid  out  1  decision flipped this cycle (pulse)
- flip_var, flip_val  out  VAR_BITS/1  flipped variable and its new value
- bt_unsat  out  1  pulse: backtrack found no decision, formula UNSAT
- overflow, underflow  out  1  sticky error flags, cleared only by reset

## Operation
- States: IDLE, UNWIND. Reset → IDLE. count, level, all pulses and sticky flags = 0.
- IDLE command priority: backtrack > (push/pop).
  - backtrack → UNWIND. A push/pop in the same cycle is dropped.
  - push only, not full: write entry at index count, count+1. If type = 0, level+1.
  - push only, full: drop the entry, set overflow. count is unchanged.
  - pop only, not empty: count−1, unassign_valid=1, unassign_var=top_var. If top_type = 0, level−1.
  - pop only, empty: ignore and set underflow.
  - push+pop, not empty: replace the top entry; count is unchanged. unassign is emitted for the old top. level is adjusted for both the old and new type.
  - push+pop, empty: behaves as push only.
- UNWIND, evaluated once per cycle on the current top:
  - empty: bt_unsat=1 → IDLE.
  - top forced: pop it, count−1, unassign_valid=1 with top_var.
  - top decision: rewrite in place as {forced, !val, var}, level−1, flip_valid=1, flip_var/flip_val = var/!val → IDLE. count is unchanged.
- Commands received in UNWIND are ignored with no error flag.
- Reset asserted mid-UNWIND: immediate IDLE and empty. No completion pulse is emitted.

## Timing
- All state is registered on posedge clock. Top outputs, empty, full and busy are combinational from registered state.
- Push/pop take effect one cycle after the sampled edge. A push followed by a pop on the next cycle is legal.
- unassign/flip/bt_unsat are single-cycle pulses, registered with the state update they describe.
- Backtrack with k forced entries above the newest decision:
  - busy is high for k+1 cycles.
  - unassign pulses on cycles 1..k.
  - flip on cycle k+1.
  - The next command is accepted on cycle k+2.
- Backtrack with no decision and k entries: k unassign pulses, then bt_unsat on cycle k+1.

## Structure
- Shared package sat_pkg holds:
  - entry_t enum: DECIDE=1'b0, FORCED=1'b1.
  - trail_entry_t packed struct {type, val, var[VAR_BITS]}.
  - trail_state_t enum.
- One sub-module, trail_mem: DEPTH×trail_entry_t register array with one write port and one combinational read port at count−1. No reset is needed on the data.

## Test plan
- Reset, then push D(v3,1), F(v5,0), F(v7,1) → count=3, level=1, top=F/1/7.
- Backtrack on that state:
  - busy high for 3 cycles.
  - unassign v7, then v5.
  - flip_var=3, flip_val=0.
  - Final state: count=1, level=0, top=F/0/3.
- Push F(v1,1), F(v2,0), then backtrack → unassign v2, v1, then bt_unsat; count=0.
- DEPTH=4: push 5 entries → count=4, full=1, overflow=1, top unchanged. Pop on empty after reset → underflow=1.
- push+pop same cycle with top D(v4,0) and new F(v6,1) → count unchanged, level−1, unassign v4, top=F/1/6.
- Reset asserted on cycle 2 of a 3-cycle unwind → next cycle IDLE, count=0, no flip or bt_unsat pulse.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types for the DPLL trail: entry kind, packed trail entry and trail FSM states.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

package sat_pkg;

   localparam int DEF_VAR_BITS = `MAX_VARS_BITS;

   typedef enum logic {
      DECIDE = 1'b0,
      FORCED = 1'b1
   } entry_t;

   typedef struct packed {
      entry_t                  etype;
      logic                    val;
      logic [DEF_VAR_BITS-1:0] vidx;
   } trail_entry_t;

   typedef enum logic {
      IDLE   = 1'b0,
      UNWIND = 1'b1
   } trail_state_t;

endpackage

// File: rtl/trail_mem.sv
// Trail entry storage: one write port, one combinational read port (the stack top).
module trail_mem #(
   parameter int DEPTH      = 64,
   parameter int WIDTH      = 10,
   parameter int ADDR_BITS  = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [WIDTH-1:0]     rd_data
);

   // Entry contents need no reset; count gates what is visible.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trail_stack.sv
// Assignment trail LIFO with decision-level tracking and a hardware backtrack
// that unwinds forced entries and flips the newest decision in place.
//
// state  | meaning
// IDLE   | accepts push / pop / backtrack commands
// UNWIND | one forced entry popped per cycle until a decision is flipped or the trail empties
module trail_stack
   import sat_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int VAR_BITS = `MAX_VARS_BITS,
   parameter int CNT_BITS = $clog2(DEPTH+1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                push,
   input  logic                push_type,
   input  logic                push_val,
   input  logic [VAR_BITS-1:0] push_var,
   input  logic                pop,
   input  logic                backtrack,
   output logic                top_type,
   output logic                top_val,
   output logic [VAR_BITS-1:0] top_var,
   output logic [CNT_BITS-1:0] count,
   output logic [CNT_BITS-1:0] level,
   output logic                empty,
   output logic                full,
   output logic                busy,
   output logic                unassign_valid,
   output logic [VAR_BITS-1:0] unassign_var,
   output logic                flip_valid,
   output logic [VAR_BITS-1:0] flip_var,
   output logic                flip_val,
   output logic                bt_unsat,
   output logic                overflow,
   output logic                underflow
);

   localparam int ADDR_BITS  = $clog2(DEPTH);
   localparam int ENTRY_BITS = VAR_BITS + 2;

   trail_state_t          state_q;
   logic [CNT_BITS-1:0]   count_q, level_q, top_idx;
   logic                  unassign_valid_q, flip_valid_q, flip_val_q, bt_unsat_q;
   logic [VAR_BITS-1:0]   unassign_var_q, flip_var_q;
   logic                  overflow_q, underflow_q;

   logic                  wr_en;
   logic [ADDR_BITS-1:0]  wr_addr, rd_addr;
   logic [ENTRY_BITS-1:0] wr_entry, rd_entry;
   logic                  raw_type, raw_val, top_dec, push_dec;
   logic [VAR_BITS-1:0]   raw_var;
   logic                  idle_cmd, replace;

   assign top_idx = count_q - 1'b1;
   assign rd_addr = top_idx[ADDR_BITS-1:0];
   assign {raw_type, raw_val, raw_var} = rd_entry;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_BITS'(DEPTH));
   assign busy     = (state_q == UNWIND);
   assign top_dec  = (entry_t'(raw_type) == DECIDE);
   assign push_dec = (entry_t'(push_type) == DECIDE);
   assign idle_cmd = (state_q == IDLE) && !backtrack;
   assign replace  = push && pop && !empty;

   assign top_type = empty ? 1'b0 : raw_type;
   assign top_val  = empty ? 1'b0 : raw_val;
   assign top_var  = empty ? '0 : raw_var;

   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = count_q[ADDR_BITS-1:0];
      wr_entry = {push_type, push_val, push_var};
      if (idle_cmd && push) begin
         if (replace) begin
            wr_en   = 1'b1;
            wr_addr = rd_addr;
         end else if (!full) begin
            wr_en = 1'b1;
         end
      end else if (state_q == UNWIND && !empty && top_dec) begin
         wr_en    = 1'b1;
         wr_addr  = rd_addr;
         wr_entry = {FORCED, ~raw_val, raw_var};
      end
   end

   trail_mem #(
      .DEPTH     (DEPTH),
      .WIDTH     (ENTRY_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_entry),
      .rd_addr (rd_addr),
      .rd_data (rd_entry)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         count_q          <= '0;
         level_q          <= '0;
         unassign_valid_q <= 1'b0;
         unassign_var_q   <= '0;
         flip_valid_q     <= 1'b0;
         flip_var_q       <= '0;
         flip_val_q       <= 1'b0;
         bt_unsat_q       <= 1'b0;
         overflow_q       <= 1'b0;
         underflow_q      <= 1'b0;
      end else begin
         unassign_valid_q <= 1'b0;
         flip_valid_q     <= 1'b0;
         bt_unsat_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (backtrack) begin
                  state_q <= UNWIND;
               end else if (push && replace) begin
                  // Level loses the old top's decision and gains the new one's.
                  level_q          <= level_q + CNT_BITS'(push_dec) - CNT_BITS'(top_dec);
                  unassign_valid_q <= 1'b1;
                  unassign_var_q   <= raw_var;
               end else if (push) begin
                  if (full) begin
                     overflow_q <= 1'b1;
                  end else begin
                     count_q <= count_q + 1'b1;
                     level_q <= level_q + CNT_BITS'(push_dec);
                  end
               end else if (pop) begin
                  if (empty) begin
                     underflow_q <= 1'b1;
                  end else begin
                     count_q          <= count_q - 1'b1;
                     level_q          <= level_q - CNT_BITS'(top_dec);
                     unassign_valid_q <= 1'b1;
                     unassign_var_q   <= raw_var;
                  end
               end
            end
            UNWIND: begin
               if (empty) begin
                  bt_unsat_q <= 1'b1;
                  state_q    <= IDLE;
               end else if (!top_dec) begin
                  count_q          <= count_q - 1'b1;
                  unassign_valid_q <= 1'b1;
                  unassign_var_q   <= raw_var;
               end else begin
                  level_q      <= level_q - 1'b1;
                  flip_valid_q <= 1'b1;
                  flip_var_q   <= raw_var;
                  flip_val_q   <= ~raw_val;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign count          = count_q;
   assign level          = level_q;
   assign unassign_valid = unassign_valid_q;
   assign unassign_var   = unassign_var_q;
   assign flip_valid     = flip_valid_q;
   assign flip_var       = flip_var_q;
   assign flip_val       = flip_val_q;
   assign bt_unsat       = bt_unsat_q;
   assign overflow       = overflow_q;
   assign underflow      = underflow_q;

endmodule
